rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares a 4:1 mux datapath (mux4_1 select pair) among four requesters.
- Issues a one-hot grant and drives the mux select lines {sel1, sel0} to the granted requester index.
- Limits each owner's tenure to MAX_HOLD cycles while others are waiting, and hands off back-to-back with no idle bubble.
- Sits directly ahead of the mux; the mux's i0..i3 are the requesters' data, and the mux output goes to the shared sink.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while another request is pending (legal range 1..15).
- HOLD_W, 4, hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  reset; synchronous, active-low.
- req  input  4  request lines; req[k] high means requester k wants the mux.
- grant  output  4  one-hot grant, or 0000 when idle; registered.
- sel0  output  1  mux select LSB = granted index bit 0; registered.
- sel1  output  1  mux select MSB = granted index bit 1; registered.
- busy  output  1  high when any grant is active; always equals |grant.

Behaviour:
- Reset (reset_n==0 at posedge) produces:
  - grant=0000, sel1=0, sel0=0, busy=0.
  - state=IDLE, ptr=0, hold_cnt=0.
  - This overrides everything else, including mid-grant.
- Winner search: the first k with req[k]==1, scanning cyclically from ptr (ptr, ptr+1, ... mod 4).
- State IDLE:
  - If any req is high, the next edge sets grant[k]=1, {sel1,sel0}=k, busy=1, hold_cnt=1, state=GRANT.
  - Latency is one cycle from req sampled to grant visible.
  - Otherwise all outputs hold. sel keeps its last value so the mux input does not glitch.
- State GRANT, owner k, evaluated each edge in priority order:
  - req[k]==0 (release):
    - ptr<=k+1 mod 4.
    - If another req is pending, grant the new winner on the same edge with no idle cycle; hold_cnt<=1.
    - Else grant<=0000, busy<=0, state<=IDLE, and sel holds.
  - req[k]==1, hold_cnt==MAX_HOLD, and another req pending (preempt):
    - ptr<=k+1.
    - Grant the winner searched from k+1; k itself is found last, so it never re-wins.
    - hold_cnt<=1.
  - req[k]==1, hold_cnt==MAX_HOLD, no other req: keep the grant; hold_cnt saturates at MAX_HOLD (no wrap).
  - Otherwise keep the grant; hold_cnt<=hold_cnt+1.
- ptr changes only when ownership ends (release or preempt), never on the initial grant from IDLE.
- sel changes only on the same edge as a grant change.
- Invariants:
  - grant is one-hot or zero.
  - {sel1,sel0} equals the index of the grant bit whenever busy==1.
- MAX_HOLD=1: under contention, ownership rotates every cycle.
- Requests arriving or dropping on the handoff edge follow the same rule: req values sampled at that edge decide the winner.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=4 and SEL_W=2.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - typedef logic [SEL_W-1:0] req_idx_t.
- Sub-module rr_pick (combinational) takes req[3:0] and start[1:0], and returns found plus idx[1:0].
  - It is instantiated once.
  - The start input is muxed between ptr and k+1.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with req=1111 -> grant=0000, sel=00, busy=0. Release reset -> grant=0001, sel=00 one edge later.
- Single requester: req=0100 from IDLE -> next edge grant=0100, {sel1,sel0}=10, busy=1. Drop req -> next edge grant=0000, busy=0, sel stays 10.
- Rotation with MAX_HOLD=8 and req=1111 held:
  - grant=0001 for 8 cycles, then 0010 for 8 cycles, then 0100, then 1000, then 0001 again.
  - sel tracks 00, 01, 10, 11.
- Back-to-back handoff: owner 0 with req=1011; drop req[0] (req=1010) -> next edge grant=0010 with no zero cycle. Drop req[1] -> next edge grant=1000.
- Saturation: only req[2] high for 20 cycles -> grant=0100 every cycle, with no drop after cycle 8. Then raise req[0] -> next edge grant=0001.
- Reset mid-grant: with grant=1000, pull reset_n=0 -> next edge grant=0000 and ptr=0. Release reset with req=1001 -> grant=0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
//   N_REQ       : number of requesters sharing the 4:1 mux
//   SEL_W       : width of the mux select / requester index
//   arb_state_t : arbiter FSM state
//   req_idx_t   : requester index type
//   idx_to_onehot : index -> one-hot grant vector
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [SEL_W-1:0] req_idx_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req        : request lines, req[k] = requester k wants the mux
//   grant      : registered one-hot grant (0 when idle)
//   sel1, sel0 : registered mux select = granted index
//   busy       : |grant
// master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic             sel0;
    logic             sel1;
    logic             busy;

    modport master (
        output req,
        input  grant,
        input  sel0,
        input  sel1,
        input  busy
    );

    modport slave (
        input  req,
        output grant,
        output sel0,
        output sel1,
        output busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational cyclic priority search.
//   req_i   : request vector
//   start_i : index searched first; search wraps start, start+1, ... mod N_REQ
//   found_o : some request is set
//   idx_o   : first set request found (start_i when none)
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  req_idx_t         start_i,
    output logic             found_o,
    output req_idx_t         idx_o
);

    req_idx_t cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = start_i;
        for (int i = 0; i < N_REQ; i++) begin
            // 2-bit addition wraps naturally, giving the cyclic scan order
            cand = start_i + req_idx_t'(i);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux.
//   clk      : clock, all state on posedge
//   reset_n  : synchronous active-low reset
//   bus      : slave side of rr_mux_arbiter_if (req in; grant, sel1/sel0, busy out)
// An owner keeps the mux until it drops its request, or until it has held it
// MAX_HOLD cycles while someone else waits. Handoffs happen on a single edge.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    rr_mux_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    req_idx_t          ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    req_idx_t          sel_q, sel_d;

    logic              pick_found;
    req_idx_t          pick_idx;
    req_idx_t          pick_start;
    req_idx_t          owner_next;
    logic              owner_req;
    logic              others_pending;
    logic              hold_max;

    // While busy, sel_q is the owner index.
    assign owner_next     = sel_q + req_idx_t'(1);
    assign owner_req      = bus.req[sel_q];
    assign others_pending = |(bus.req & ~grant_q);
    assign hold_max       = (hold_q == HOLD_W'(MAX_HOLD));

    // From IDLE search from ptr; once owned, any handoff searches from owner+1,
    // which equals the ptr value written on that same edge.
    assign pick_start = (state_q == GRANT) ? owner_next : ptr_q;

    rr_pick u_pick (
        .req_i   (bus.req),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    ptr_d = owner_next;
                    if (pick_found) begin
                        grant_d = idx_to_onehot(pick_idx);
                        sel_d   = pick_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        // sel left alone so the mux input does not move
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_max && others_pending) begin
                    // Owner is scanned last from owner+1, so another requester wins
                    ptr_d   = owner_next;
                    grant_d = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end else if (!hold_max) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel0  = sel_q[0];
    assign bus.sel1  = sel_q[1];
    assign bus.busy  = |grant_q;

endmodule
